// File: rtl/vga_fb_pkg.sv
// Shared timing constants, bus types and pixel helpers for the VGA frame-buffer reader.
package vga_fb_pkg;

  localparam int unsigned H_VIS     = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned V_VIS     = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;
  localparam int unsigned FB_W      = 320;
  localparam int unsigned FB_H      = 240;
  localparam int unsigned FB_ADDR_W = 17;
  localparam int unsigned FB_DATA_W = 16;
  localparam int unsigned CNT_W     = 10;
  localparam int unsigned COL_W     = 4;

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic vis;
  } vga_ctrl_t;

  typedef struct packed {
    logic [COL_W-1:0] r;
    logic [COL_W-1:0] g;
    logic [COL_W-1:0] b;
  } rgb444_t;

  localparam vga_ctrl_t CTRL_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, vis: 1'b0};

  // Keep the top nibble of each RGB565 field.
  function automatic rgb444_t rgb565_to_444(input logic [FB_DATA_W-1:0] px);
    rgb444_t c;
    c.r = COL_W'(px >> 12);
    c.g = COL_W'(px >> 7);
    c.b = COL_W'(px >> 1);
    return c;
  endfunction

  // (y/2)*320 + x/2 built from shifts; 239*320+319 = 76799 fits in 17 bits.
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [CNT_W-1:0] x,
                                                   input logic [CNT_W-1:0] y);
    logic [FB_ADDR_W-1:0] row;
    row = FB_ADDR_W'(y >> 1);
    return (row << 8) + (row << 6) + FB_ADDR_W'(x >> 1);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel/line counters with raw (unpipelined) sync, visible flag and frame-wrap pulse.
module vga_timing_gen
  import vga_fb_pkg::*;
#(
  parameter int unsigned P_H_VIS  = H_VIS,
  parameter int unsigned P_H_FP   = H_FP,
  parameter int unsigned P_H_SYNC = H_SYNC,
  parameter int unsigned P_H_BP   = H_BP,
  parameter int unsigned P_V_VIS  = V_VIS,
  parameter int unsigned P_V_FP   = V_FP,
  parameter int unsigned P_V_SYNC = V_SYNC,
  parameter int unsigned P_V_BP   = V_BP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_pix_tick,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output vga_ctrl_t        o_ctrl_c,
  output logic             o_frame_start_c
);

  localparam int unsigned H_TOT    = P_H_VIS + P_H_FP + P_H_SYNC + P_H_BP;
  localparam int unsigned V_TOT    = P_V_VIS + P_V_FP + P_V_SYNC + P_V_BP;
  localparam int unsigned HS_FIRST = P_H_VIS + P_H_FP;
  localparam int unsigned HS_LAST  = HS_FIRST + P_H_SYNC - 1;
  localparam int unsigned VS_FIRST = P_V_VIS + P_V_FP;
  localparam int unsigned VS_LAST  = VS_FIRST + P_V_SYNC - 1;

  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             w_x_wrap;
  logic             w_y_wrap;

  assign w_x_wrap = (r_x == CNT_W'(H_TOT - 1));
  assign w_y_wrap = (r_y == CNT_W'(V_TOT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_pix_tick) begin
      if (w_x_wrap) begin
        r_x <= '0;
        r_y <= w_y_wrap ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  always_comb begin
    o_ctrl_c      = CTRL_IDLE;
    o_ctrl_c.hs_n = !((r_x >= CNT_W'(HS_FIRST)) && (r_x <= CNT_W'(HS_LAST)));
    o_ctrl_c.vs_n = !((r_y >= CNT_W'(VS_FIRST)) && (r_y <= CNT_W'(VS_LAST)));
    o_ctrl_c.vis  = (r_x < CNT_W'(P_H_VIS)) && (r_y < CNT_W'(P_V_VIS));
  end

  assign o_x             = r_x;
  assign o_y             = r_y;
  assign o_frame_start_c = i_pix_tick & w_x_wrap & w_y_wrap;

endmodule

// File: rtl/vga_framebuffer_reader.sv
// 640x480 VGA scan-out of a 320x240 RGB565 frame buffer with 2x pixel doubling.
module vga_framebuffer_reader
  import vga_fb_pkg::*;
#(
  parameter int unsigned P_H_VIS  = H_VIS,
  parameter int unsigned P_H_FP   = H_FP,
  parameter int unsigned P_H_SYNC = H_SYNC,
  parameter int unsigned P_H_BP   = H_BP,
  parameter int unsigned P_V_VIS  = V_VIS,
  parameter int unsigned P_V_FP   = V_FP,
  parameter int unsigned P_V_SYNC = V_SYNC,
  parameter int unsigned P_V_BP   = V_BP
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pix_tick,
  output logic [FB_ADDR_W-1:0] rAddr,
  input  logic [FB_DATA_W-1:0] rData,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [COL_W-1:0]     red,
  output logic [COL_W-1:0]     green,
  output logic [COL_W-1:0]     blue,
  output logic                 frame_start
);

  logic [CNT_W-1:0]     w_x;
  logic [CNT_W-1:0]     w_y;
  vga_ctrl_t            w_ctrl_c;
  logic                 w_frame_start_c;
  vga_ctrl_t            r_ctrl_s0;
  vga_ctrl_t            r_ctrl_s1;
  logic                 r_tick_d;
  logic [FB_DATA_W-1:0] r_word;
  logic [FB_DATA_W-1:0] w_word;
  rgb444_t              w_rgb;

  vga_timing_gen #(
    .P_H_VIS (P_H_VIS),
    .P_H_FP  (P_H_FP),
    .P_H_SYNC(P_H_SYNC),
    .P_H_BP  (P_H_BP),
    .P_V_VIS (P_V_VIS),
    .P_V_FP  (P_V_FP),
    .P_V_SYNC(P_V_SYNC),
    .P_V_BP  (P_V_BP)
  ) u_timing (
    .clk            (clk),
    .reset          (reset),
    .i_pix_tick     (pix_tick),
    .o_x            (w_x),
    .o_y            (w_y),
    .o_ctrl_c       (w_ctrl_c),
    .o_frame_start_c(w_frame_start_c)
  );

  // The RAM word for the previous stage-0 address is on rData one clk after that tick;
  // r_word keeps it for sparse ticks, while back-to-back ticks take rData directly.
  assign w_word = r_tick_d ? rData : r_word;
  assign w_rgb  = r_ctrl_s1.vis ? rgb565_to_444(w_word) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rAddr     <= '0;
      r_ctrl_s0 <= CTRL_IDLE;
      r_ctrl_s1 <= CTRL_IDLE;
      r_tick_d  <= 1'b0;
      r_word    <= '0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      de        <= 1'b0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
    end else begin
      r_tick_d <= pix_tick;
      if (r_tick_d) begin
        r_word <= rData;
      end
      if (pix_tick) begin
        if (w_ctrl_c.vis) begin
          rAddr <= fb_addr(w_x, w_y);
        end
        r_ctrl_s0 <= w_ctrl_c;
        r_ctrl_s1 <= r_ctrl_s0;
        hsync     <= r_ctrl_s1.hs_n;
        vsync     <= r_ctrl_s1.vs_n;
        de        <= r_ctrl_s1.vis;
        red       <= w_rgb.r;
        green     <= w_rgb.g;
        blue      <= w_rgb.b;
      end
    end
  end

  assign frame_start = w_frame_start_c;

endmodule
